// File: rtl/aemb2_mdu_pkg.sv
// Shared definitions for the AEMB2 multiply/divide unit: op codes, FSM states,
// multiplier depth bounds.
package aemb2_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_IDIV   = 3'd4,
    MDU_IDIVU  = 3'd5
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  localparam int unsigned MUL_STAGES_MIN = 1;
  localparam int unsigned MUL_STAGES_MAX = 4;

  function automatic logic is_mul_op(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/aemb2_mdu_div.sv
// Iterative radix-2 restoring divider: one entry cycle (magnitudes, zero test),
// then one quotient bit per cycle. Sign fix-up is left to the caller.
module aemb2_mdu_div
  import aemb2_mdu_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          gena,
  input  logic          start_i,
  input  logic          kill_i,
  input  logic          sgn_i,
  input  logic [DW-1:0] dvs_i,
  input  logic [DW-1:0] dvd_i,
  output logic          done_o,
  output logic          dz_o,
  output logic          neg_o,
  output logic [DW-1:0] quo_o
);

  localparam int unsigned CW = $clog2(DW) + 1;

  logic          ent_q, run_q, sgn_q, neg_q, dz_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] dvs_q, rem_q, quo_q;
  logic [DW:0]   trial;
  logic          fits;
  logic [DW-1:0] dvs_abs, dvd_abs;

  always_comb begin
    trial   = {rem_q, quo_q[DW-1]} - {1'b0, dvs_q};
    fits    = ~trial[DW];
    dvs_abs = (sgn_q && dvs_q[DW-1]) ? -dvs_q : dvs_q;
    dvd_abs = (sgn_q && quo_q[DW-1]) ? -quo_q : quo_q;
  end

  // A zero divisor skips the arithmetic but still paces the counter, finishing
  // one count early so it lands two cycles ahead of a normal divide.
  assign done_o = run_q && (cnt_q == (dz_q ? CW'(1) : CW'(0)));
  assign dz_o   = dz_q;
  assign neg_o  = neg_q;
  assign quo_o  = quo_q;

  always_ff @(posedge gclk) begin
    if (grst) begin
      ent_q <= 1'b0;
      run_q <= 1'b0;
      sgn_q <= 1'b0;
      neg_q <= 1'b0;
      dz_q  <= 1'b0;
      cnt_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
    end else if (gena) begin
      if (kill_i) begin
        ent_q <= 1'b0;
        run_q <= 1'b0;
      end else if (start_i) begin
        ent_q <= 1'b1;
        run_q <= 1'b0;
        sgn_q <= sgn_i;
        dvs_q <= dvs_i;
        quo_q <= dvd_i;
      end else if (ent_q) begin
        ent_q <= 1'b0;
        run_q <= 1'b1;
        dvs_q <= dvs_abs;
        quo_q <= dvd_abs;
        rem_q <= '0;
        neg_q <= sgn_q & (dvs_q[DW-1] ^ quo_q[DW-1]);
        dz_q  <= (dvs_q == '0);
        cnt_q <= CW'(DW - 1);
      end else if (run_q) begin
        if (!dz_q) begin
          rem_q <= fits ? trial[DW-1:0] : {rem_q[DW-2:0], quo_q[DW-1]};
          quo_q <= {quo_q[DW-2:0], fits};
        end
        if (done_o) run_q <= 1'b0;
        else        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/aemb2_mdu.sv
// AEMB2 multi-cycle multiply/divide unit: control FSM, pipelined multiplier
// and an optional iterative divider.
module aemb2_mdu
  import aemb2_mdu_pkg::*;
#(
  parameter int unsigned DW         = 32,
  parameter int unsigned MUL_STAGES = 2,
  parameter bit          DIV_EN     = 1'b1
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          gena,
  input  logic          stb_i,
  input  logic          kill_i,
  input  logic [2:0]    op_i,
  input  logic [DW-1:0] opa_i,
  input  logic [DW-1:0] opb_i,
  output logic          busy_o,
  output logic          ack_o,
  output logic [DW-1:0] result_o,
  output logic          dz_o
);

  localparam int unsigned MS = (MUL_STAGES < MUL_STAGES_MIN) ? MUL_STAGES_MIN :
                               (MUL_STAGES > MUL_STAGES_MAX) ? MUL_STAGES_MAX : MUL_STAGES;

  mdu_state_e    state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [1:0]    mcnt_q, mcnt_d;
  logic [DW-1:0] res_q, res_d;
  logic          dz_q, dz_d;

  // Multiplier: operands extended to 2*DW per op, the truncated product is exact.
  logic          sa, sb;
  logic [2*DW-1:0] xa, xb, prod;
  logic [DW-1:0] mres, mpipe_out;

  always_comb begin
    sa   = (op_q == MDU_MULH) || (op_q == MDU_MULHSU);
    sb   = (op_q == MDU_MULH);
    xa   = {{DW{sa & opa_q[DW-1]}}, opa_q};
    xb   = {{DW{sb & opb_q[DW-1]}}, opb_q};
    prod = xa * xb;
    mres = (op_q == MDU_MUL) ? prod[DW-1:0] : prod[2*DW-1:DW];
  end

  if (MS == 1) begin : g_nopipe
    assign mpipe_out = mres;
  end else begin : g_pipe
    logic [DW-1:0] pipe_q [MS-1];
    always_ff @(posedge gclk) begin
      if (grst) begin
        pipe_q <= '{default: '0};
      end else if (gena) begin
        pipe_q[0] <= mres;
        for (int unsigned i = 1; i < MS - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign mpipe_out = pipe_q[MS-2];
  end

  logic          div_start, div_sgn, div_done, div_dz, div_neg;
  logic [DW-1:0] div_quo;

  assign div_sgn = (op_i == MDU_IDIV);

  if (DIV_EN) begin : g_div
    aemb2_mdu_div #(.DW(DW)) u_div (
      .gclk    (gclk),
      .grst    (grst),
      .gena    (gena),
      .start_i (div_start),
      .kill_i  (kill_i),
      .sgn_i   (div_sgn),
      .dvs_i   (opa_i),
      .dvd_i   (opb_i),
      .done_o  (div_done),
      .dz_o    (div_dz),
      .neg_o   (div_neg),
      .quo_o   (div_quo)
    );
  end else begin : g_nodiv
    assign div_done = 1'b0;
    assign div_dz   = 1'b0;
    assign div_neg  = 1'b0;
    assign div_quo  = '0;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    mcnt_d    = mcnt_q;
    res_d     = res_q;
    dz_d      = dz_q;
    div_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (stb_i && !kill_i) begin
          op_d  = op_i;
          opa_d = opa_i;
          opb_d = opb_i;
          if (is_mul_op(op_i)) begin
            state_d = ST_MUL;
            mcnt_d  = 2'(MS - 1);
          end else if (DIV_EN && (op_i == MDU_IDIV || op_i == MDU_IDIVU)) begin
            state_d   = ST_DIV;
            div_start = 1'b1;
          end else begin
            state_d = ST_DONE;
            res_d   = '0;
            dz_d    = 1'b0;
          end
        end
      end
      ST_MUL: begin
        if (kill_i) begin
          state_d = ST_IDLE;
        end else if (mcnt_q == 2'd0) begin
          state_d = ST_DONE;
          res_d   = mpipe_out;
          dz_d    = 1'b0;
        end else begin
          mcnt_d = mcnt_q - 2'd1;
        end
      end
      ST_DIV: begin
        if (kill_i) begin
          state_d = ST_IDLE;
        end else if (div_done) begin
          if (div_dz) begin
            state_d = ST_DONE;
            res_d   = '0;
            dz_d    = 1'b1;
          end else begin
            state_d = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        if (kill_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          res_d   = div_neg ? -div_quo : div_quo;
          dz_d    = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      mcnt_q  <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
    end else if (gena) begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      mcnt_q  <= mcnt_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end

  assign busy_o   = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
  assign ack_o    = (state_q == ST_DONE);
  assign result_o = res_q;
  assign dz_o     = dz_q;

endmodule

// File: doc/aemb2_mdu.md
Name: aemb2_mdu

Overview:
- Multi-cycle multiply/divide unit for the next-generation AEMB execution stage.
- Replaces the single-cycle stalled 32-bit multiply with:
  - a pipelined multiplier of parametrised width and depth, including high-word products;
  - an iterative radix-2 signed/unsigned divider (IDIV/IDIVU).
- Sits beside the main ALU. The pipeline control stalls issue while busy_o is high and writes back result_o on ack_o.

Parameters:
- DW, 32: operand and result width; even, >= 8.
- MUL_STAGES, 2: multiplier latency in cycles, 1..4. Register stages are retimed by synthesis.
- DIV_EN, 1: 0 removes the divider; divide ops then ack after 1 cycle with result 0.

Ports:
- gclk  in  1  clock
- grst  in  1  reset, synchronous, active-high
- gena  in  1  global enable; when low, all state holds (reset still acts)
- stb_i  in  1  operation request, sampled in IDLE only
- kill_i  in  1  abort the in-flight operation (branch skip / interrupt)
- op_i  in  3  0=MUL(low), 1=MULH(s×s), 2=MULHSU(s×u), 3=MULHU(u×u), 4=IDIV, 5=IDIVU; 6,7 reserved
- opa_i  in  DW  multiplicand / divisor
- opb_i  in  DW  multiplier / dividend
- busy_o  out  1  operation in flight
- ack_o  out  1  one-cycle completion pulse
- result_o  out  DW  result, valid from ack_o and held until the next accepted stb_i
- dz_o  out  1  divide-by-zero flag, valid with ack_o and held like result_o

Behaviour:
- Reset values: busy_o=0, ack_o=0, result_o=0, dz_o=0, state=IDLE.
- Each clause below applies only on cycles with gena=1.
- States and transitions:
  - IDLE
    - stb_i=1 latches op_i, opa_i and opb_i, and sets busy_o=1 next cycle.
    - Valid op: MUL-class goes to MUL, divide goes to DIV.
    - Reserved op: goes to DONE with result 0.
  - MUL
    - Counts MUL_STAGES-1 cycles, then goes to DONE.
    - Product is 2·DW bits. Operands are sign-extended per op (MULHSU: opa signed, opb unsigned).
    - MUL returns the low DW bits; MULH/MULHSU/MULHU return the high DW bits.
  - DIV
    - Entry: takes absolute values of the operands for IDIV.
    - opa=0: skip iteration, result=0, dz=1, go to DONE.
    - Otherwise runs DW restoring-division iterations (1 quotient bit per cycle), then goes to FIX.
  - FIX
    - IDIV only: negates the quotient if the operand signs differ.
    - Goes to DONE.
  - DONE
    - ack_o=1 for exactly this cycle with result_o and dz_o valid; busy_o drops in the same cycle.
    - Returns to IDLE. A new stb_i is accepted in the following cycle.
- Latency from stb_i to ack_o:
  - MUL-class: MUL_STAGES+1 cycles.
  - Divide: DW+3 cycles (DW+1 for divide by zero).
  - Reserved op: 1 cycle.
- Division semantics: quotient = opb / opa, truncated toward zero; the remainder is discarded.
  - IDIV of the most-negative value by −1 returns the most-negative value (0x80000000 at DW=32), dz=0.
- stb_i while busy_o=1 is ignored; no queueing.
- kill_i=1 in any non-IDLE state:
  - returns to IDLE next cycle with busy_o=0;
  - no ack_o; result_o and dz_o keep their previous values.
- kill_i together with stb_i in IDLE: the request is dropped.
- kill_i in DONE: ack_o is already asserted and stands.
- gena=0 mid-operation freezes the iteration counter and datapath. Completion is delayed by exactly the number of frozen cycles.
- grst mid-operation: immediate return to reset values; no ack.
- The iteration counter is $clog2(DW)+1 bits and counts down from DW−1 to 0.

Decomposition:
- Shared package aemb2_mdu_pkg holds:
  - op encodings (MDU_MUL..MDU_IDIVU);
  - the state enum (IDLE, MUL, DIV, FIX, DONE);
  - the MUL_STAGES bound constants.
- One natural sub-module, aemb2_mdu_div: the iterative divider datapath.
  - Contains the remainder/quotient shift registers and the counter.
  - Interface: start, kill, done handshake.
- The FSM and multiplier pipe stay in the top module.

Test Plan:
- MUL 0x0000FFFF×0x00010001 (DW=32, MUL_STAGES=2) -> ack at cycle 3 after stb; result 0xFFFFFFFF.
- MULH 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000; MULHU with the same operands -> 0xFFFFFFFE.
- IDIV opb=−7 (0xFFFFFFF9), opa=2 -> result 0xFFFFFFFD after 35 cycles; IDIVU opb=0xFFFFFFF9, opa=2 -> 0x7FFFFFFC.
- IDIV opa=0, opb=5 -> ack after 33 cycles, result 0, dz_o=1. IDIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, dz_o=0.
- Start IDIVU, assert kill_i at cycle 10 -> busy_o=0 next cycle, no ack_o, result_o unchanged. A stb_i during busy is ignored; a subsequent MUL completes normally.
- During IDIV, hold gena=0 for 5 cycles -> ack delayed by exactly 5 cycles with the correct result. grst at cycle 4 -> all outputs 0.
